// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared sequence constants, FSM state type and byte lookup
// Purpose: single source of the 8-byte framing sequence used by the checker
//          and by any sequence generator, plus the checker state encoding.
// Contents: SEQ_LEN, SEQ_BYTES (index 0 in the low byte), state_t, seq_byte().
package seq_pkg;

    localparam int SEQ_LEN = 8;

    // Byte i of the sequence lives at bits [8*i +: 8].
    localparam logic [63:0] SEQ_BYTES = {
        8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
    };

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [7:0] seq_byte(input logic [2:0] i);
        return SEQ_BYTES[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with synchronous clear that sticks at all-ones
// Purpose: shared counter for the mismatch total and the consecutive-miss run.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset, clears count
//   clr     - synchronous clear, wins over en
//   en      - increment request, ignored once saturated
//   count   - current value (W bits)
//   sat     - high while count is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - byte-stream alignment checker against the seq_pkg pattern
// Purpose: hunts for the 8-byte sequence, locks after one full matched pass,
//          flags mismatches while locked and drops lock after LOSS_THRESH
//          consecutive misses. Optional statistics under SEQ_CHK_STATS_EN.
// Ports:
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset
//   valid     - qualifies data on a clk edge
//   data      - received byte
//   locked    - high while in LOCKED
//   error     - one-cycle pulse, cycle after a LOCKED mismatch
//   err_count - saturating total of LOCKED mismatches (ERR_W bits)
//   seq_count - wrapping count of clean sequences (0 unless SEQ_CHK_STATS_EN)
module sequence_checker
    import seq_pkg::*;
#(
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [7:0]       data,
    output logic             locked,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      seq_count
);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] miss_count;
    logic       miss_sat;
    logic       err_sat;

    logic       match;
    logic       locked_sample;
    logic       locked_miss;
    logic       loss;

    assign match         = (data == seq_byte(idx));
    assign locked_sample = valid && (state == ST_LOCKED);
    assign locked_miss   = locked_sample && !match;
    // The miss that would take the run to LOSS_THRESH drops lock right away.
    assign loss          = locked_miss && (miss_count == 4'(LOSS_THRESH - 1));

    sat_counter #(.W(ERR_W)) u_err_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (1'b0),
        .en      (locked_miss),
        .count   (err_count),
        .sat     (err_sat)
    );

    sat_counter #(.W(4)) u_miss_count (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (locked_sample && (match || loss)),
        .en      (locked_miss),
        .count   (miss_count),
        .sat     (miss_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_HUNT;
            idx    <= 3'd0;
            locked <= 1'b0;
            error  <= 1'b0;
        end else begin
            error <= locked_miss;
            if (valid) begin
                case (state)
                    ST_HUNT: begin
                        if (match) begin
                            state <= ST_SYNC;
                            idx   <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (match) begin
                            // Matching index 0 again means 8 bytes in a row matched.
                            if (idx == 3'd0) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                            idx <= idx + 3'd1;
                        end else begin
                            state <= ST_HUNT;
                            idx   <= 3'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (loss) begin
                            state  <= ST_HUNT;
                            idx    <= 3'd0;
                            locked <= 1'b0;
                        end else begin
                            // Advance even on a miss so one bad byte keeps alignment.
                            idx <= idx + 3'd1;
                        end
                    end
                    default: begin
                        state  <= ST_HUNT;
                        idx    <= 3'd0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_CHK_STATS_EN
    // clean: every byte of the current sequence so far has matched.
    logic        clean;
    logic [15:0] seq_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean       <= 1'b0;
            seq_count_q <= 16'd0;
        end else if (valid) begin
            if (state == ST_SYNC && match && idx == 3'd0) begin
                clean <= 1'b1;
            end else if (state == ST_LOCKED) begin
                if (idx == 3'd0) begin
                    clean <= match;
                end else begin
                    clean <= clean && match;
                end
                if (idx == 3'd7 && match && clean) begin
                    seq_count_q <= seq_count_q + 16'd1;
                end
            end
        end
    end

    assign seq_count = seq_count_q;
`else
    assign seq_count = 16'd0;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - directed self-checking bench for sequence_checker
module tb_sequence_checker;
    import seq_pkg::*;

    localparam int ERR_W = 2;
`ifdef SEQ_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             valid = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             locked;
    logic             error;
    logic [ERR_W-1:0] err_count;
    logic [15:0]      seq_count;

    int tests = 0;
    int fails = 0;

    sequence_checker #(.LOSS_THRESH(3), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (valid),
        .data      (data),
        .locked    (locked),
        .error     (error),
        .err_count (err_count),
        .seq_count (seq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic el,
                        input logic ee, input logic [ERR_W-1:0] ec, input string tag);
        @(negedge clk);
        valid = v;
        data  = b;
        @(posedge clk);
        #1;
        chk({tag, "/locked"}, 32'(locked), 32'(el));
        chk({tag, "/error"}, 32'(error), 32'(ee));
        chk({tag, "/err_count"}, 32'(err_count), 32'(ec));
    endtask

    task automatic feed(input int start, input int n, input logic el,
                        input logic [ERR_W-1:0] ec, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, seq_byte(3'(start + i)), el, 1'b0, ec, tag);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst/locked", 32'(locked), 32'd0);
        chk("rst/error", 32'(error), 32'd0);
        chk("rst/err_count", 32'(err_count), 32'd0);
        chk("rst/seq_count", 32'(seq_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // First lock: AF plus 8 matched bytes, lock on the second AF
        feed(0, 8, 1'b0, 2'd0, "prelock");
        step(1'b1, 8'hAF, 1'b1, 1'b0, 2'd0, "lock");

        // Single corrupted FF: one pulse, alignment kept
        feed(1, 3, 1'b1, 2'd0, "pre_ff");
        step(1'b1, 8'h00, 1'b1, 1'b1, 2'd1, "ff_corrupt");
        step(1'b1, 8'hE2, 1'b1, 1'b0, 2'd1, "e2_after");
        feed(6, 2, 1'b1, 2'd1, "tail_dirty");
        chk("seq_after_dirty", 32'(seq_count), 32'd0);

        // valid low with garbage mid-sequence
        feed(0, 3, 1'b1, 2'd1, "pre_gap");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h11 * 8'(i + 1), 1'b1, 1'b0, 2'd1, "gap");
        end
        feed(3, 5, 1'b1, 2'd1, "post_gap");
        chk("seq_after_gap", 32'(seq_count), STATS ? 32'd1 : 32'd0);

        // Three more clean sequences
        for (int s = 0; s < 3; s++) begin
            feed(0, 8, 1'b1, 2'd1, "clean_seq");
        end
        chk("seq_four", 32'(seq_count), STATS ? 32'd4 : 32'd0);

        // Asynchronous reset mid-sequence
        feed(0, 3, 1'b1, 2'd1, "pre_rst");
        #2;
        valid   = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst/locked", 32'(locked), 32'd0);
        chk("arst/error", 32'(error), 32'd0);
        chk("arst/err_count", 32'(err_count), 32'd0);
        chk("arst/seq_count", 32'(seq_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Old alignment discarded: rest of old sequence does not lock
        feed(3, 5, 1'b0, 2'd0, "stale");
        step(1'b1, 8'hAF, 1'b0, 1'b0, 2'd0, "fresh_af");
        feed(1, 7, 1'b0, 2'd0, "resync");
        step(1'b1, 8'hAF, 1'b1, 1'b0, 2'd0, "relock");

        // Loss of lock after three consecutive misses
        step(1'b1, 8'hBC, 1'b1, 1'b0, 2'd0, "pre_loss");
        step(1'b1, 8'h00, 1'b1, 1'b1, 2'd1, "miss1");
        step(1'b1, 8'h00, 1'b1, 1'b1, 2'd2, "miss2");
        step(1'b1, 8'h00, 1'b0, 1'b1, 2'd3, "miss3_loss");
        step(1'b1, 8'hFF, 1'b0, 1'b0, 2'd3, "hunt_hold");

        // Aborted sync returns to HUNT
        step(1'b1, 8'hBC, 1'b0, 1'b0, 2'd3, "abort_bc");
        step(1'b1, 8'hE2, 1'b0, 1'b0, 2'd3, "abort_e2");
        step(1'b1, 8'hAF, 1'b0, 1'b0, 2'd3, "abort_af");
        step(1'b1, 8'hBC, 1'b0, 1'b0, 2'd3, "abort_bc2");
        step(1'b1, 8'h00, 1'b0, 1'b0, 2'd3, "abort_00");
        step(1'b1, 8'hE2, 1'b0, 1'b0, 2'd3, "hunt_e2");
        feed(3, 5, 1'b0, 2'd3, "hunt_tail");
        step(1'b1, 8'hAF, 1'b0, 1'b0, 2'd3, "no_lock_from_hunt");
        feed(1, 7, 1'b0, 2'd3, "resync2");
        step(1'b1, 8'hAF, 1'b1, 1'b0, 2'd3, "relock2");

        // Saturation and miss-run cleared by a match
        step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, "sat_miss1");
        step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, "sat_miss2");
        step(1'b1, 8'h78, 1'b1, 1'b0, 2'd3, "match_clears");
        step(1'b1, 8'h00, 1'b1, 1'b1, 2'd3, "miss_after_clear");
        step(1'b1, 8'hE2, 1'b1, 1'b0, 2'd3, "still_aligned");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
